// File: rtl/alu_seq_pkg.sv
// Shared types and op-classification helpers for the 32-bit ALU sequencer
// that drives the 16-bit bit-sliced ALU.
package alu_seq_pkg;

    localparam int ALU_XLEN    = 32;
    localparam int ALU_SLICE_W = 16;

    typedef enum logic [3:0] {
        ALU_OP_ADD,
        ALU_OP_SUB,
        ALU_OP_PLUS_4,
        ALU_OP_AND,
        ALU_OP_OR,
        ALU_OP_XOR,
        ALU_OP_EQ,
        ALU_OP_LT,
        ALU_OP_LTU,
        ALU_OP_SLL,
        ALU_OP_SRL,
        ALU_OP_SRA
    } cs_alu_op;

    typedef enum logic [1:0] {
        IDLE,
        PASS1,
        PASS2,
        RESP
    } alu_seq_state_e;

    // How the PASS1 slice result lands in the 32-bit result, and what fills the rest.
    typedef enum logic [1:0] {
        FILL_SPLIT,
        FILL_ZERO_HI,
        FILL_SIGN_HI,
        FILL_ZERO_LO
    } fill_sel_e;

    function automatic logic is_shift(input cs_alu_op op);
        return op inside {ALU_OP_SLL, ALU_OP_SRL, ALU_OP_SRA};
    endfunction

    function automatic logic is_cmp(input cs_alu_op op);
        return op inside {ALU_OP_EQ, ALU_OP_LT, ALU_OP_LTU};
    endfunction

    function automatic logic hi_first(input cs_alu_op op);
        return op inside {ALU_OP_SRL, ALU_OP_SRA};
    endfunction

endpackage

// File: rtl/alu_half_order.sv
// Decides pass ordering, pass count, result fill and the shift-amount operand
// for one sequencer operation.
module alu_half_order
    import alu_seq_pkg::*;
#(
    parameter int SLICE_W = ALU_SLICE_W
) (
    input  cs_alu_op           op_i,
    input  logic [4:0]         amt_i,
    output logic               hi_first_o,
    output logic               single_pass_o,
    output fill_sel_e          fill_sel_o,
    output logic [SLICE_W-1:0] shift_b_o
);

    logic big_shift;

    // NOTE: every output gets a default before any branch, so no latch is inferred.
    always_comb begin
        big_shift     = is_shift(op_i) && amt_i[4];
        hi_first_o    = hi_first(op_i);
        single_pass_o = big_shift;
        fill_sel_o    = FILL_SPLIT;
        shift_b_o     = SLICE_W'(amt_i);
        if (amt_i[4]) begin
            shift_b_o = SLICE_W'(amt_i[3:0]);
        end
        if (big_shift) begin
            unique case (op_i)
                ALU_OP_SRL: fill_sel_o = FILL_ZERO_HI;
                ALU_OP_SRA: fill_sel_o = FILL_SIGN_HI;
                default:    fill_sel_o = FILL_ZERO_LO;
            endcase
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequences a 32-bit ALU request over the 16-bit slice in one or two passes.
// Optional: define ALU_SEQ_EARLY_EQ_EN to finish EQ after PASS1 when the low halves differ.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int XLEN    = ALU_XLEN,
    parameter int SLICE_W = ALU_SLICE_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  cs_alu_op           req_op_i,
    input  logic               req_flip_i,
    input  logic [XLEN-1:0]    req_a_i,
    input  logic [XLEN-1:0]    req_b_i,
    output cs_alu_op           alu_op_o,
    output logic               alu_cmp_flip_o,
    output logic               alu_first_cycle_o,
    output logic [SLICE_W-1:0] alu_a_o,
    output logic [SLICE_W-1:0] alu_b_o,
    input  logic [SLICE_W-1:0] alu_result_i,
    input  logic               alu_cmp_result_i,
    input  logic               alu_cmp_result_valid_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [XLEN-1:0]    rsp_result_o,
    output logic               rsp_cmp_o
);

    alu_seq_state_e     state_q, state_d;
    cs_alu_op           op_q, op_d;
    logic               flip_q, flip_d;
    logic [XLEN-1:0]    a_q, a_d;
    logic [XLEN-1:0]    b_q, b_d;
    logic [XLEN-1:0]    res_q, res_d;
    logic               cmp_q, cmp_d;

    logic               hi_first_w;
    logic               single_pass_w;
    fill_sel_e          fill_sel_w;
    logic [SLICE_W-1:0] shift_b_w;
    logic               drive_hi;
    logic               early_eq;

    alu_half_order #(.SLICE_W(SLICE_W)) u_half_order (
        .op_i          (op_q),
        .amt_i         (b_q[4:0]),
        .hi_first_o    (hi_first_w),
        .single_pass_o (single_pass_w),
        .fill_sel_o    (fill_sel_w),
        .shift_b_o     (shift_b_w)
    );

`ifdef ALU_SEQ_EARLY_EQ_EN
    assign early_eq = (op_q == ALU_OP_EQ) && alu_cmp_result_valid_i;
`else
    logic unused_cmp_valid;
    assign unused_cmp_valid = alu_cmp_result_valid_i;
    assign early_eq         = 1'b0;
`endif

    // NOTE: synchronous reset clears the whole datapath so the response port reads zero after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            op_q    <= ALU_OP_ADD;
            flip_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cmp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            flip_q  <= flip_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cmp_q   <= cmp_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        op_d              = op_q;
        flip_d            = flip_q;
        a_d               = a_q;
        b_d               = b_q;
        res_d             = res_q;
        cmp_d             = cmp_q;
        alu_first_cycle_o = 1'b0;
        alu_a_o           = '0;
        alu_b_o           = '0;
        drive_hi          = (state_q == PASS1) ? hi_first_w : !hi_first_w;

        if (state_q == PASS1 || state_q == PASS2) begin
            alu_a_o = drive_hi ? a_q[XLEN-1:SLICE_W] : a_q[SLICE_W-1:0];
            alu_b_o = is_shift(op_q) ? shift_b_w
                    : (drive_hi ? b_q[XLEN-1:SLICE_W] : b_q[SLICE_W-1:0]);
            cmp_d   = is_cmp(op_q) && alu_cmp_result_i;
        end

        unique case (state_q)
            IDLE: begin
                if (req_valid_i) begin
                    op_d    = req_op_i;
                    flip_d  = req_flip_i;
                    a_d     = req_a_i;
                    b_d     = req_b_i;
                    state_d = PASS1;
                end
            end
            PASS1: begin
                alu_first_cycle_o = 1'b1;
                unique case (fill_sel_w)
                    FILL_ZERO_HI: res_d = {{SLICE_W{1'b0}}, alu_result_i};
                    FILL_SIGN_HI: res_d = {{SLICE_W{a_q[XLEN-1]}}, alu_result_i};
                    FILL_ZERO_LO: res_d = {alu_result_i, {SLICE_W{1'b0}}};
                    default: begin
                        if (hi_first_w) res_d[XLEN-1:SLICE_W] = alu_result_i;
                        else            res_d[SLICE_W-1:0]    = alu_result_i;
                    end
                endcase
                state_d = (single_pass_w || early_eq) ? RESP : PASS2;
            end
            PASS2: begin
                if (hi_first_w) res_d[SLICE_W-1:0]    = alu_result_i;
                else            res_d[XLEN-1:SLICE_W] = alu_result_i;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign req_ready_o    = (state_q == IDLE);
    assign rsp_valid_o    = (state_q == RESP);
    assign rsp_result_o   = is_cmp(op_q) ? XLEN'(cmp_q) : res_q;
    assign rsp_cmp_o      = cmp_q;
    assign alu_op_o       = op_q;
    assign alu_cmp_flip_o = flip_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: plays the slice by hand, checks slice drive,
// result assembly, latency, backpressure and mid-operation reset.
module tb_alu_seq;
    import alu_seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid_i;
    logic        req_ready_o;
    cs_alu_op    req_op_i;
    logic        req_flip_i;
    logic [31:0] req_a_i;
    logic [31:0] req_b_i;
    cs_alu_op    alu_op_o;
    logic        alu_cmp_flip_o;
    logic        alu_first_cycle_o;
    logic [15:0] alu_a_o;
    logic [15:0] alu_b_o;
    logic [15:0] alu_result_i;
    logic        alu_cmp_result_i;
    logic        alu_cmp_result_valid_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [31:0] rsp_result_o;
    logic        rsp_cmp_o;

    int       n_tests = 0;
    int       n_fail  = 0;
    cs_alu_op cur_op;
    logic     cur_flip;

    always #5 clk = ~clk;

    alu_seq dut (
        .clk                    (clk),
        .rst                    (rst),
        .req_valid_i            (req_valid_i),
        .req_ready_o            (req_ready_o),
        .req_op_i               (req_op_i),
        .req_flip_i             (req_flip_i),
        .req_a_i                (req_a_i),
        .req_b_i                (req_b_i),
        .alu_op_o               (alu_op_o),
        .alu_cmp_flip_o         (alu_cmp_flip_o),
        .alu_first_cycle_o      (alu_first_cycle_o),
        .alu_a_o                (alu_a_o),
        .alu_b_o                (alu_b_o),
        .alu_result_i           (alu_result_i),
        .alu_cmp_result_i       (alu_cmp_result_i),
        .alu_cmp_result_valid_i (alu_cmp_result_valid_i),
        .rsp_valid_o            (rsp_valid_o),
        .rsp_ready_i            (rsp_ready_i),
        .rsp_result_o           (rsp_result_o),
        .rsp_cmp_o              (rsp_cmp_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present a request in an IDLE cycle; returns just after the accepting edge.
    task automatic issue(input cs_alu_op op, input logic flip, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        check("req_ready", 32'(req_ready_o), 32'd1);
        req_valid_i = 1'b1;
        req_op_i    = op;
        req_flip_i  = flip;
        req_a_i     = a;
        req_b_i     = b;
        cur_op      = op;
        cur_flip    = flip;
        @(posedge clk);
        #1 req_valid_i = 1'b0;
    endtask

    // One slice cycle: check what the sequencer drives, then answer as the slice.
    task automatic pass(input string tag, input logic [15:0] ea, input logic [15:0] eb, input logic efc,
                        input logic [15:0] res, input logic cmp, input logic cv);
        @(negedge clk);
        check({tag, ".a"},    32'(alu_a_o),           32'(ea));
        check({tag, ".b"},    32'(alu_b_o),           32'(eb));
        check({tag, ".fc"},   32'(alu_first_cycle_o), 32'(efc));
        check({tag, ".op"},   32'(alu_op_o),          32'(cur_op));
        check({tag, ".flip"}, 32'(alu_cmp_flip_o),    32'(cur_flip));
        check({tag, ".rspv"}, 32'(rsp_valid_o),       32'd0);
        alu_result_i           = res;
        alu_cmp_result_i       = cmp;
        alu_cmp_result_valid_i = cv;
    endtask

    // Expect the response now, hold it for 'stall' extra cycles, then consume it.
    task automatic resp(input string tag, input logic [31:0] er, input logic ec, input int stall);
        for (int i = 0; i <= stall; i++) begin
            @(negedge clk);
            alu_result_i           = 16'h0;
            alu_cmp_result_i       = 1'b0;
            alu_cmp_result_valid_i = 1'b0;
            check({tag, ".rspv"},  32'(rsp_valid_o),  32'd1);
            check({tag, ".res"},   rsp_result_o,      er);
            check({tag, ".cmp"},   32'(rsp_cmp_o),    32'(ec));
            check({tag, ".ready"}, 32'(req_ready_o),  32'd0);
            if (i == stall) rsp_ready_i = 1'b1;
        end
        @(posedge clk);
        #1 rsp_ready_i = 1'b0;
    endtask

    initial begin
        rst                    = 1'b1;
        req_valid_i            = 1'b0;
        req_op_i               = ALU_OP_ADD;
        req_flip_i             = 1'b0;
        req_a_i                = '0;
        req_b_i                = '0;
        alu_result_i           = '0;
        alu_cmp_result_i       = 1'b0;
        alu_cmp_result_valid_i = 1'b0;
        rsp_ready_i            = 1'b0;
        cur_op                 = ALU_OP_ADD;
        cur_flip               = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst.ready", 32'(req_ready_o),       32'd1);
        check("rst.rspv",  32'(rsp_valid_o),       32'd0);
        check("rst.res",   rsp_result_o,           32'h0);
        check("rst.cmp",   32'(rsp_cmp_o),         32'd0);
        check("rst.fc",    32'(alu_first_cycle_o), 32'd0);
        check("rst.a",     32'(alu_a_o),           32'h0);
        check("rst.b",     32'(alu_b_o),           32'h0);
        check("rst.op",    32'(alu_op_o),          32'(ALU_OP_ADD));

        // ADD with carry across the halves
        issue(ALU_OP_ADD, 1'b0, 32'h0000FFFF, 32'h00000001);
        pass("add.p1", 16'hFFFF, 16'h0001, 1'b1, 16'h0000, 1'b0, 1'b0);
        pass("add.p2", 16'h0000, 16'h0000, 1'b0, 16'h0001, 1'b0, 1'b0);
        resp("add", 32'h00010000, 1'b0, 0);

        // Small SRL: high half first, amount in both passes
        issue(ALU_OP_SRL, 1'b0, 32'h80000000, 32'd4);
        pass("srl.p1", 16'h8000, 16'h0004, 1'b1, 16'h0800, 1'b0, 1'b0);
        pass("srl.p2", 16'h0000, 16'h0004, 1'b0, 16'h0000, 1'b0, 1'b0);
        resp("srl", 32'h08000000, 1'b0, 0);

        // Large SRA: single pass, sign fill
        issue(ALU_OP_SRA, 1'b0, 32'h80000000, 32'd20);
        pass("sra.p1", 16'h8000, 16'h0004, 1'b1, 16'hF800, 1'b0, 1'b0);
        resp("sra", 32'hFFFFF800, 1'b0, 0);

        // Large SRL: single pass, zero fill
        issue(ALU_OP_SRL, 1'b0, 32'hF0000000, 32'd16);
        pass("srlb.p1", 16'hF000, 16'h0000, 1'b1, 16'hF000, 1'b0, 1'b0);
        resp("srlb", 32'h0000F000, 1'b0, 0);

        // Large SLL: single pass into the high half
        issue(ALU_OP_SLL, 1'b0, 32'h00000001, 32'd17);
        pass("sll.p1", 16'h0001, 16'h0001, 1'b1, 16'h0002, 1'b0, 1'b0);
        resp("sll", 32'h00020000, 1'b0, 0);

        // SLL by zero takes the normal low-first path
        issue(ALU_OP_SLL, 1'b0, 32'hABCD1234, 32'hFFFF0000);
        pass("sll0.p1", 16'h1234, 16'h0000, 1'b1, 16'h1234, 1'b0, 1'b0);
        pass("sll0.p2", 16'hABCD, 16'h0000, 1'b0, 16'hABCD, 1'b0, 1'b0);
        resp("sll0", 32'hABCD1234, 1'b0, 0);

        // EQ, low halves differ
        issue(ALU_OP_EQ, 1'b0, 32'h12340001, 32'h12340002);
        pass("eqd.p1", 16'h0001, 16'h0002, 1'b1, 16'h0000, 1'b0, 1'b1);
`ifndef ALU_SEQ_EARLY_EQ_EN
        pass("eqd.p2", 16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b1);
`endif
        resp("eqd", 32'h0, 1'b0, 0);

        // EQ, equal operands: decision only in PASS2
        issue(ALU_OP_EQ, 1'b0, 32'hCAFE0005, 32'hCAFE0005);
        pass("eqs.p1", 16'h0005, 16'h0005, 1'b1, 16'h0000, 1'b0, 1'b0);
        pass("eqs.p2", 16'hCAFE, 16'hCAFE, 1'b0, 16'h0000, 1'b1, 1'b1);
        resp("eqs", 32'h1, 1'b1, 0);

        // BNE-style: flip forwarded, slice returns the flipped bit
        issue(ALU_OP_EQ, 1'b1, 32'h12340001, 32'h12340002);
        pass("ne.p1", 16'h0001, 16'h0002, 1'b1, 16'h0000, 1'b1, 1'b1);
`ifndef ALU_SEQ_EARLY_EQ_EN
        pass("ne.p2", 16'h1234, 16'h1234, 1'b0, 16'h0000, 1'b1, 1'b1);
`endif
        resp("ne", 32'h1, 1'b1, 0);

        // LTU decided in the high half
        issue(ALU_OP_LTU, 1'b0, 32'h00000005, 32'h00010000);
        pass("ltu.p1", 16'h0005, 16'h0000, 1'b1, 16'h0005, 1'b0, 1'b0);
        pass("ltu.p2", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b1);
        resp("ltu", 32'h1, 1'b1, 0);

        // Backpressure: hold for 3 cycles with a competing request pending
        issue(ALU_OP_OR, 1'b0, 32'h00F000F0, 32'h0F000F00);
        pass("bp.p1", 16'h00F0, 16'h0F00, 1'b1, 16'h0FF0, 1'b0, 1'b0);
        pass("bp.p2", 16'h00F0, 16'h0F00, 1'b0, 16'h0FF0, 1'b0, 1'b0);
        req_valid_i = 1'b1;
        req_op_i    = ALU_OP_SUB;
        resp("bp", 32'h0FF00FF0, 1'b0, 3);
        req_valid_i = 1'b0;
        @(negedge clk);
        check("bp.idle_ready", 32'(req_ready_o), 32'd1);
        check("bp.idle_rspv",  32'(rsp_valid_o), 32'd0);

        // Reset during PASS2 drops the operation
        issue(ALU_OP_XOR, 1'b0, 32'h0F0F0F0F, 32'hFFFF0000);
        pass("rx.p1", 16'h0F0F, 16'h0000, 1'b1, 16'h0F0F, 1'b0, 1'b0);
        @(negedge clk);
        check("rx.p2fc", 32'(alu_first_cycle_o), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rx.ready", 32'(req_ready_o),       32'd1);
        check("rx.rspv",  32'(rsp_valid_o),       32'd0);
        check("rx.res",   rsp_result_o,           32'h0);
        check("rx.cmp",   32'(rsp_cmp_o),         32'd0);
        check("rx.fc",    32'(alu_first_cycle_o), 32'd0);
        check("rx.a",     32'(alu_a_o),           32'h0);
        check("rx.b",     32'(alu_b_o),           32'h0);
        check("rx.op",    32'(alu_op_o),          32'(ALU_OP_ADD));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rx.quiet", 32'(rsp_valid_o), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
